// File: rtl/lieat_ifu_bpu.sv
// rtl/lieat_ifu_bpu.sv - static-index 2-bit BHT branch predictor with EXU training and perf counters
module lieat_ifu_bpu #(
  parameter int         XLEN     = 32,
  parameter int         BPU_IDX  = 4,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ifu_valid,
  input  logic               ifu_bxx,
  input  logic [XLEN-1:0]    ifu_pc,
  input  logic [XLEN-1:0]    ifu_imm,
  output logic               bpu_prdt,
  output logic [XLEN-1:0]    bpu_prdt_pc,
  input  logic               upd_en,
  input  logic [BPU_IDX-1:0] upd_index,
  input  logic               upd_res,
  input  logic               exu_flush,
  input  logic               perf_clr,
  output logic [31:0]        perf_br_cnt,
  output logic [31:0]        perf_miss_cnt
);

  localparam int DEPTH = 1 << BPU_IDX;

  logic [1:0]         bht [DEPTH];
  logic [BPU_IDX-1:0] lkp_idx;
  logic [1:0]         upd_old;
  logic [1:0]         upd_new;
  logic [1:0]         lkp_ctr;
  logic               byp_hit;

  assign lkp_idx = ifu_pc[BPU_IDX+1:2];
  assign upd_old = bht[upd_index];

  // Saturating next value of the counter being trained this cycle
  always_comb begin
    upd_new = upd_old;
    if (upd_res) begin
      if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
    end else begin
      if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
    end
  end

  // Same-cycle training of the looked-up entry is forwarded; during reset the table reads CNT_INIT only
  assign byp_hit     = reset & upd_en & (upd_index == lkp_idx);
  assign lkp_ctr     = byp_hit ? upd_new : bht[lkp_idx];
  assign bpu_prdt    = ifu_valid & ifu_bxx & lkp_ctr[1];
  assign bpu_prdt_pc = ifu_pc + (bpu_prdt ? ifu_imm : XLEN'(4));

  // Counter table: async init, one trained entry per cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= CNT_INIT;
    end else if (upd_en) begin
      bht[upd_index] <= upd_new;
    end
  end

  // Branch and mispredict counters; clear takes priority over increment
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_br_cnt   <= 32'd0;
      perf_miss_cnt <= 32'd0;
    end else if (perf_clr) begin
      perf_br_cnt   <= 32'd0;
      perf_miss_cnt <= 32'd0;
    end else begin
      perf_br_cnt   <= perf_br_cnt + {31'd0, upd_en};
      perf_miss_cnt <= perf_miss_cnt + {31'd0, exu_flush};
    end
  end

endmodule

// File: tb/tb_lieat_ifu_bpu.sv
// tb/tb_lieat_ifu_bpu.sv - scoreboard bench for lieat_ifu_bpu
module tb_lieat_ifu_bpu;

  logic        clock;
  logic        reset;
  logic        ifu_valid;
  logic        ifu_bxx;
  logic [31:0] ifu_pc;
  logic [31:0] ifu_imm;
  logic        bpu_prdt;
  logic [31:0] bpu_prdt_pc;
  logic        upd_en;
  logic [3:0]  upd_index;
  logic        upd_res;
  logic        exu_flush;
  logic        perf_clr;
  logic [31:0] perf_br_cnt;
  logic [31:0] perf_miss_cnt;

  lieat_ifu_bpu #(.XLEN(32), .BPU_IDX(4), .CNT_INIT(2'b01)) dut (
    .clock(clock), .reset(reset),
    .ifu_valid(ifu_valid), .ifu_bxx(ifu_bxx), .ifu_pc(ifu_pc), .ifu_imm(ifu_imm),
    .bpu_prdt(bpu_prdt), .bpu_prdt_pc(bpu_prdt_pc),
    .upd_en(upd_en), .upd_index(upd_index), .upd_res(upd_res),
    .exu_flush(exu_flush), .perf_clr(perf_clr),
    .perf_br_cnt(perf_br_cnt), .perf_miss_cnt(perf_miss_cnt)
  );

  typedef struct {
    logic        prdt;
    logic [31:0] pc;
    logic [31:0] br;
    logic [31:0] miss;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;

  // reference model: counters as integers 0..3, perf as plain counts
  int          mctr[16];
  logic [31:0] mbr;
  logic [31:0] mmiss;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic int sat(input int c, input logic r);
    int n;
    n = r ? c + 1 : c - 1;
    if (n > 3) n = 3;
    if (n < 0) n = 0;
    return n;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mctr[i] = 1;
    mbr   = 32'd0;
    mmiss = 32'd0;
  endtask

  // one cycle of stimulus: drive, push the expected response, advance the model
  task automatic drive(input logic v, input logic b, input logic [31:0] pc, input logic [31:0] imm,
                       input logic ue, input logic [3:0] ui, input logic ur,
                       input logic fl, input logic cl);
    exp_t e;
    int   c;
    logic p;
    @(posedge clock);
    #1;
    ifu_valid = v; ifu_bxx = b; ifu_pc = pc; ifu_imm = imm;
    upd_en = ue; upd_index = ui; upd_res = ur; exu_flush = fl; perf_clr = cl;
    c = mctr[pc[5:2]];
    if (ue && ui == pc[5:2]) c = sat(c, ur);
    p = v && b && (c >= 2);
    e.prdt = p;
    e.pc   = pc + (p ? imm : 32'd4);
    e.br   = mbr;
    e.miss = mmiss;
    exp_q.push_back(e);
    if (ue) mctr[ui] = sat(mctr[ui], ur);
    if (cl) begin
      mbr   = 32'd0;
      mmiss = 32'd0;
    end else begin
      mbr   = mbr + (ue ? 32'd1 : 32'd0);
      mmiss = mmiss + (fl ? 32'd1 : 32'd0);
    end
  endtask

  // monitor: compares the DUT against the oldest pending expectation each cycle
  always @(negedge clock) begin
    exp_t e;
    if (reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("bpu_prdt", {31'd0, bpu_prdt}, {31'd0, e.prdt});
      check("bpu_prdt_pc", bpu_prdt_pc, e.pc);
      check("perf_br_cnt", perf_br_cnt, e.br);
      check("perf_miss_cnt", perf_miss_cnt, e.miss);
    end
  end

  initial begin
    int wait_cnt;
    model_reset();
    reset = 1'b0;
    ifu_valid = 1'b1; ifu_bxx = 1'b1; ifu_pc = 32'h8000_0010; ifu_imm = 32'h40;
    upd_en = 1'b1; upd_index = 4'd4; upd_res = 1'b1; exu_flush = 1'b1; perf_clr = 1'b0;
    #2;
    check("rst_prdt", {31'd0, bpu_prdt}, 32'd0);
    check("rst_prdt_pc", bpu_prdt_pc, 32'h8000_0014);
    check("rst_br", perf_br_cnt, 32'd0);
    check("rst_miss", perf_miss_cnt, 32'd0);
    #8;
    upd_en = 1'b0; exu_flush = 1'b0;
    reset = 1'b1;

    // first lookup after reset: weakly not-taken
    drive(1, 1, 32'h8000_0010, 32'h40, 0, 0, 0, 0, 0);
    // train idx 4 twice, look up, saturate with a third
    drive(0, 0, 32'h0, 32'h0, 1, 4, 1, 0, 0);
    drive(0, 0, 32'h0, 32'h0, 1, 4, 1, 0, 0);
    drive(1, 1, 32'h8000_0010, 32'h40, 0, 0, 0, 0, 0);
    drive(0, 0, 32'h0, 32'h0, 1, 4, 1, 0, 0);
    drive(1, 1, 32'h8000_0010, 32'h40, 0, 0, 0, 0, 0);
    // aliased pc with higher bits different maps to the same entry
    drive(1, 1, 32'h1234_5010, 32'hFFFF_FFF0, 0, 0, 0, 0, 0);
    // non-branch with strong-taken entry, and pc wrap
    drive(1, 0, 32'h8000_0010, 32'h40, 0, 0, 0, 0, 0);
    drive(1, 0, 32'hFFFF_FFFC, 32'h40, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h8000_0010, 32'h40, 0, 0, 0, 0, 0);
    // bypass: idx 8 at 01 trained taken in the same cycle as its lookup
    drive(1, 1, 32'h8000_0020, 32'h40, 1, 8, 1, 0, 0);
    drive(1, 1, 32'h8000_0020, 32'h40, 0, 0, 0, 0, 0);
    // train idx 8 down past zero
    for (int i = 0; i < 4; i++) drive(1, 1, 32'h8000_0020, 32'h40, 1, 8, 0, 0, 0);
    drive(1, 1, 32'h8000_0020, 32'h40, 1, 8, 1, 0, 0);

    // perf: clear, 5 updates with 2 flushes, then clear colliding with an update
    drive(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 32'h0, 32'h0, 1, 4'(i), 1, (i < 2), 0);
    drive(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    drive(0, 0, 32'h0, 32'h0, 1, 3, 0, 1, 1);
    drive(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
    end

    // push every entry to strong-taken, then async reset mid-cycle with an update in flight
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 3; k++) drive(0, 0, 32'h0, 32'h0, 1, 4'(i), 1, 1, 0);
    drive(1, 1, 32'h8000_0010, 32'h40, 1, 4, 1, 1, 0);
    @(negedge clock);
    #2;
    ifu_valid = 1'b1; ifu_bxx = 1'b1; ifu_pc = 32'h8000_0010; ifu_imm = 32'h40;
    upd_en = 1'b1; upd_index = 4'd4; upd_res = 1'b1; exu_flush = 1'b1;
    reset = 1'b0;
    model_reset();
    #1;
    check("midrst_prdt", {31'd0, bpu_prdt}, 32'd0);
    check("midrst_prdt_pc", bpu_prdt_pc, 32'h8000_0014);
    check("midrst_br", perf_br_cnt, 32'd0);
    check("midrst_miss", perf_miss_cnt, 32'd0);
    @(posedge clock);
    #1;
    check("rsthold_prdt", {31'd0, bpu_prdt}, 32'd0);
    check("rsthold_br", perf_br_cnt, 32'd0);
    @(negedge clock);
    upd_en = 1'b0; exu_flush = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) drive(1, 1, {26'h200_0000, 4'(i), 2'b00}, 32'h100, 0, 0, 0, 0, 0);
    drive(1, 1, 32'h8000_0010, 32'h40, 1, 4, 1, 0, 0);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(negedge clock);
      #1;
      wait_cnt++;
    end
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
